// File: rtl/ysyx_22041211_wbu_pkg.sv
// Shared definitions for the write-back unit: FSM state encodings and the
// machine-mode CSR addresses the core writes through this stage.
package ysyx_22041211_wbu_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_WRITE = 2'b01,
    WB_DONE  = 2'b10,
    WB_HALT  = 2'b11
  } wb_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

endpackage

// File: rtl/ysyx_22041211_retire_cnt.sv
// 64-bit retired-instruction counter; wraps silently, reset has priority over inc.
module ysyx_22041211_retire_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// Write-back unit: accepts one LSU result, performs GPR/CSR writes for one cycle,
// retires the instruction, then hands the committed next PC to the IFU (or halts on ebreak).
module ysyx_22041211_wbu
  import ysyx_22041211_wbu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid_i,
  output logic                wbu_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic                csr_wen_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic [ADDR_LEN-1:0] dnpc_i,
  input  logic                ebreak_i,
  input  logic                ifu_ready_i,
  output logic                reg_wen_o,
  output logic [4:0]          reg_waddr_o,
  output logic [DATA_LEN-1:0] reg_wdata_o,
  output logic                csr_wen_o,
  output logic [11:0]         csr_waddr_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                wbu_valid_o,
  output logic [ADDR_LEN-1:0] next_pc_o,
  output logic [63:0]         minstret_o,
  output logic                halt_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds valid and payload stable until that edge.

  wb_state_e           state_q, state_d;
  logic                wd_q, wd_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic                csr_wen_q, csr_wen_d;
  logic [11:0]         csr_addr_q, csr_addr_d;
  logic [DATA_LEN-1:0] csr_wdata_q, csr_wdata_d;
  logic [ADDR_LEN-1:0] dnpc_q, dnpc_d;
  logic                ebreak_q, ebreak_d;
  logic                retire;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    csr_wen_d   = csr_wen_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    dnpc_d      = dnpc_q;
    ebreak_d    = ebreak_q;
    case (state_q)
      WB_IDLE: begin
        if (lsu_valid_i) begin
          wd_d        = wd_i;
          wreg_d      = wreg_i;
          wdata_d     = wdata_i;
          csr_wen_d   = csr_wen_i;
          csr_addr_d  = csr_addr_i;
          csr_wdata_d = csr_wdata_i;
          dnpc_d      = dnpc_i;
          ebreak_d    = ebreak_i;
          state_d     = WB_WRITE;
        end
      end
      WB_WRITE: state_d = ebreak_q ? WB_HALT : WB_DONE;
      WB_DONE: begin
        if (ifu_ready_i) begin
          state_d = WB_IDLE;
        end
      end
      WB_HALT: state_d = WB_HALT;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      wd_q        <= 1'b0;
      wreg_q      <= 5'd0;
      wdata_q     <= '0;
      csr_wen_q   <= 1'b0;
      csr_addr_q  <= 12'd0;
      csr_wdata_q <= '0;
      dnpc_q      <= '0;
      ebreak_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      csr_wen_q   <= csr_wen_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      dnpc_q      <= dnpc_d;
      ebreak_q    <= ebreak_d;
    end
  end

  // Address/data buses are zeroed whenever their strobe is low.
  always_comb begin
    wbu_ready_o = 1'b0;
    reg_wen_o   = 1'b0;
    reg_waddr_o = 5'd0;
    reg_wdata_o = '0;
    csr_wen_o   = 1'b0;
    csr_waddr_o = 12'd0;
    csr_wdata_o = '0;
    wbu_valid_o = 1'b0;
    next_pc_o   = '0;
    halt_o      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      WB_IDLE: wbu_ready_o = 1'b1;
      WB_WRITE: begin
        retire = 1'b1;
        if (wd_q && (wreg_q != 5'd0)) begin
          reg_wen_o   = 1'b1;
          reg_waddr_o = wreg_q;
          reg_wdata_o = wdata_q;
        end
        if (csr_wen_q) begin
          csr_wen_o   = 1'b1;
          csr_waddr_o = csr_addr_q;
          csr_wdata_o = csr_wdata_q;
        end
      end
      WB_DONE: begin
        wbu_valid_o = 1'b1;
        next_pc_o   = dnpc_q;
      end
      WB_HALT: halt_o = 1'b1;
      default: ;
    endcase
  end

  ysyx_22041211_retire_cnt u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .cnt_o (minstret_o)
  );

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Directed plus randomized bench for the write-back unit; expected values come
// from a transaction-level model (retire count, halt flag, per-phase outputs).
module tb_ysyx_22041211_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic        wbu_ready_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] wdata_i;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] dnpc_i;
  logic        ebreak_i;
  logic        ifu_ready_i;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        wbu_valid_o;
  logic [31:0] next_pc_o;
  logic [63:0] minstret_o;
  logic        halt_o;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_cnt = 64'd0;

  always #5 clk = ~clk;

  ysyx_22041211_wbu #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid_i),
    .wbu_ready_o (wbu_ready_o),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .csr_wen_i   (csr_wen_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .dnpc_i      (dnpc_i),
    .ebreak_i    (ebreak_i),
    .ifu_ready_i (ifu_ready_i),
    .reg_wen_o   (reg_wen_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .csr_wen_o   (csr_wen_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o),
    .wbu_valid_o (wbu_valid_o),
    .next_pc_o   (next_pc_o),
    .minstret_o  (minstret_o),
    .halt_o      (halt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit rdy, input bit rwen,
                           input logic [4:0] wa, input logic [31:0] wdat,
                           input bit cwen, input logic [11:0] ca, input logic [31:0] cdat,
                           input bit vld, input logic [31:0] pc, input bit hlt);
    chk({tag, ".ready"},     64'(wbu_ready_o), 64'(rdy));
    chk({tag, ".reg_wen"},   64'(reg_wen_o),   64'(rwen));
    chk({tag, ".reg_waddr"}, 64'(reg_waddr_o), 64'(wa));
    chk({tag, ".reg_wdata"}, 64'(reg_wdata_o), 64'(wdat));
    chk({tag, ".csr_wen"},   64'(csr_wen_o),   64'(cwen));
    chk({tag, ".csr_waddr"}, 64'(csr_waddr_o), 64'(ca));
    chk({tag, ".csr_wdata"}, 64'(csr_wdata_o), 64'(cdat));
    chk({tag, ".valid"},     64'(wbu_valid_o), 64'(vld));
    chk({tag, ".next_pc"},   64'(next_pc_o),   64'(pc));
    chk({tag, ".halt"},      64'(halt_o),      64'(hlt));
    chk({tag, ".minstret"},  minstret_o,       exp_cnt);
  endtask

  task automatic scramble_inputs();
    wd_i        = 1'($urandom_range(0, 1));
    wreg_i      = 5'($urandom_range(0, 31));
    wdata_i     = $urandom;
    csr_wen_i   = 1'($urandom_range(0, 1));
    csr_addr_i  = 12'($urandom_range(0, 4095));
    csr_wdata_i = $urandom;
    dnpc_i      = $urandom;
    ebreak_i    = 1'($urandom_range(0, 1));
  endtask

  // One full instruction from the idle state. noise keeps lsu_valid_i high with
  // junk payload while the unit is busy; it must not be accepted or latched.
  task automatic run_txn(input string tag, input bit wd, input logic [4:0] wreg,
                         input logic [31:0] wdata, input bit cwen, input logic [11:0] caddr,
                         input logic [31:0] cdata, input logic [31:0] dnpc, input bit ebrk,
                         input int stall, input bit noise);
    bit strobe;
    check_all({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lsu_valid_i = 1'b1;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    csr_wen_i = cwen; csr_addr_i = caddr; csr_wdata_i = cdata;
    dnpc_i = dnpc; ebreak_i = ebrk;
    ifu_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    strobe = wd && (wreg != 5'd0);
    check_all({tag, ".write"}, 0, strobe, strobe ? wreg : 5'd0, strobe ? wdata : 32'd0,
              cwen, cwen ? caddr : 12'd0, cwen ? cdata : 32'd0, 0, 0, 0);
    exp_cnt = exp_cnt + 64'd1;
    if (noise) scramble_inputs();
    else lsu_valid_i = 1'b0;
    @(negedge clk);
    if (ebrk) begin
      check_all({tag, ".halt"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      lsu_valid_i = 1'b0;
      return;
    end
    for (int k = 0; k <= stall; k++) begin
      check_all({tag, ".done"}, 0, 0, 0, 0, 0, 0, 0, 1, dnpc, 0);
      ifu_ready_i = (k == stall);
      if (k == stall) lsu_valid_i = 1'b0;
      else if (noise) scramble_inputs();
      @(negedge clk);
    end
  endtask

  // Start an instruction and reset it either in the write or the done phase.
  task automatic abort_txn(input string tag, input bit in_write);
    scramble_inputs();
    ebreak_i = 1'b0;
    lsu_valid_i = 1'b1;
    ifu_ready_i = 1'b0;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    if (!in_write) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 64'd0;
    check_all({tag, ".after_rst"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_all({tag, ".post"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid_i = 1'b0;
    wd_i = 1'b0; wreg_i = 5'd0; wdata_i = 32'd0;
    csr_wen_i = 1'b0; csr_addr_i = 12'd0; csr_wdata_i = 32'd0;
    dnpc_i = 32'd0; ebreak_i = 1'b0; ifu_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("basic", 1, 5'd5, 32'hDEADBEEF, 0, 12'd0, 32'd0, 32'h80000004, 0, 0, 0);
    run_txn("x0", 1, 5'd0, 32'h00001234, 0, 12'd0, 32'd0, 32'h80000008, 0, 0, 0);
    run_txn("csr_gpr", 1, 5'd10, 32'h0000_0042, 1, 12'h341, 32'h80000010, 32'h8000000C, 0, 0, 0);
    run_txn("backpressure", 1, 5'd7, 32'hCAFEF00D, 1, 12'h300, 32'h00001800, 32'h80000100, 0, 4, 1);

    for (int i = 0; i < 40; i++) begin
      int idle_gap;
      logic [4:0] r;
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_txn("rand", 1'($urandom_range(0, 1)), r, $urandom, 1'($urandom_range(0, 1)),
              12'($urandom_range(0, 4095)), $urandom, $urandom, 0,
              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      idle_gap = $urandom_range(0, 2);
      for (int g = 0; g < idle_gap; g++) begin
        check_all("gap", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
      end
    end

    abort_txn("rst_in_done", 0);
    abort_txn("rst_in_write", 1);
    run_txn("after_rst", 1, 5'd3, 32'h0BADF00D, 1, 12'h342, 32'h0000000B, 32'h80000200, 0, 1, 0);

    run_txn("ebreak", 1, 5'd10, 32'd0, 0, 12'd0, 32'd0, 32'h80000300, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      scramble_inputs();
      lsu_valid_i = 1'b1;
      ifu_ready_i = 1'b1;
      @(negedge clk);
      check_all("halted", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    lsu_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 64'd0;
    check_all("halt_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_txn("post_halt", 1, 5'd1, 32'h11111111, 0, 12'd0, 32'd0, 32'h80000000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_wbu.md
Name: ysyx_22041211_wbu

Overview:
- Write-back unit; sits directly downstream of the load/store stage and closes the multicycle loop back to the IFU.
- Captures the load/store stage's result through a valid/ready handshake.
- Performs the GPR and CSR writes, counts retired instructions, then signals the IFU with the committed next PC.
- Detects ebreak and halts the core after the final write.

Parameters:
- DATA_LEN, 32, data and register width.
- ADDR_LEN, 32, PC width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- lsu_valid_i  input  1  load/store stage result valid.
- wbu_ready_o  output  1  WBU can accept a result.
- wd_i  input  1  GPR write enable for this instruction.
- wreg_i  input  5  GPR destination index.
- wdata_i  input  DATA_LEN  GPR write data.
- csr_wen_i  input  1  CSR write enable.
- csr_addr_i  input  12  CSR address.
- csr_wdata_i  input  DATA_LEN  CSR write data.
- dnpc_i  input  ADDR_LEN  next PC computed by EXU.
- ebreak_i  input  1  instruction is ebreak.
- ifu_ready_i  input  1  IFU can accept a next PC.
- reg_wen_o  output  1  GPR write strobe.
- reg_waddr_o  output  5  GPR write index.
- reg_wdata_o  output  DATA_LEN  GPR write data.
- csr_wen_o  output  1  CSR write strobe.
- csr_waddr_o  output  12  CSR write address.
- csr_wdata_o  output  DATA_LEN  CSR write data.
- wbu_valid_o  output  1  next PC valid to IFU.
- next_pc_o  output  ADDR_LEN  committed next PC.
- minstret_o  output  64  retired-instruction count.
- halt_o  output  1  core halted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - State WB_IDLE.
  - wbu_ready_o=1; every other output 0; minstret_o=0.
  - All latched fields 0.
- FSM states, 2-bit encoding:
  - WB_IDLE (00): wbu_ready_o=1. On lsu_valid_i=1, latch every input field and go to WB_WRITE. Otherwise stay.
  - WB_WRITE (01): exactly one cycle; wbu_ready_o=0.
    - reg_wen_o = wd_q && (wreg_q != 0).
    - csr_wen_o = csr_wen_q.
    - Address and data outputs drive the latched values.
    - minstret_o increments by 1, registered, so it is visible the following cycle.
    - Next state is WB_HALT if ebreak_q=1, else WB_DONE.
  - WB_DONE (10): wbu_valid_o=1, next_pc_o=dnpc_q, held stable. When ifu_ready_i=1, go to WB_IDLE.
  - WB_HALT (11): halt_o=1, wbu_valid_o=0, wbu_ready_o=0. Absorbing; only rst exits.
- Write strobes: outside WB_WRITE, reg_wen_o and csr_wen_o are 0. Address and data outputs are 0 when not strobed.
- Latency:
  - Handshake accepted at edge T.
  - Write strobes high during cycle T+1.
  - wbu_valid_o rises at T+2 and holds until the ifu_ready_i handshake completes.
  - With ifu_ready_i tied 1, the WBU is back in WB_IDLE at T+3.
- Handshake: lsu_valid_i while wbu_ready_o=0 is ignored. The load/store stage holds its data until accepted.
- x0: writes to register 0 are suppressed. The instruction still retires and minstret_o still increments.
- Simultaneous events:
  - wd_i and csr_wen_i both set: both strobes are asserted in the same WB_WRITE cycle.
  - ebreak with wd_i set: the write happens, then halt.
- Counter wrap: minstret_o wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 silently.
- Reset mid-operation: rst in WB_WRITE or WB_DONE aborts. No strobe is issued in the cycle following reset, and no partial PC is handed to the IFU.
- Illegal state: falls back to WB_IDLE.

Decomposition:
- Shared define file: WB_IDLE, WB_WRITE, WB_DONE, WB_HALT encodings; CSR address constants (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- Sub-module ysyx_22041211_retire_cnt: 64-bit counter with inc and rst inputs, instantiated once.
- FSM and latches stay in the top module.

Test Plan:
- Basic write: lsu_valid_i=1, wd_i=1, wreg_i=5, wdata_i=0xDEADBEEF, dnpc_i=0x80000004, ifu_ready_i=1.
  - Expect reg_wen_o=1, waddr=5, wdata=0xDEADBEEF at T+1.
  - Expect wbu_valid_o=1, next_pc_o=0x80000004 at T+2.
  - Expect minstret_o=1.
- x0 suppression: wd_i=1, wreg_i=0, wdata_i=0x1234.
  - Expect reg_wen_o to stay 0 throughout.
  - Expect minstret_o to increment and wbu_valid_o to pulse.
- CSR plus GPR write: csr_wen_i=1, csr_addr_i=0x341, csr_wdata_i=0x80000010, wd_i=1, wreg_i=10.
  - Expect both strobes in the same cycle with correct address and data.
- IFU backpressure: ifu_ready_i=0 for 4 cycles after T+2.
  - Expect wbu_valid_o and next_pc_o held, wbu_ready_o=0.
  - Expect a second lsu_valid_i to be ignored until 1 cycle after ifu_ready_i=1.
- ebreak: ebreak_i=1, wd_i=1, wreg_i=10, wdata_i=0.
  - Expect reg_wen_o at T+1, then halt_o=1 from T+2 onward.
  - Expect wbu_valid_o to never assert and later lsu_valid_i to be ignored.
- Reset mid-operation: assert rst during WB_DONE.
  - Expect all outputs at reset values the next cycle, minstret_o=0, wbu_ready_o=1.
